// File: rtl/ex_pkg.sv
// Shared EX-stage types and constants for the multi-cycle divide sequencer.
package ex_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } div_state_t;

    localparam logic [31:0] DIV_QUOT_BY_ZERO = 32'hFFFF_FFFF;
    localparam logic [31:0] DIV_OVF_QUOT     = 32'h8000_0000;

    function automatic logic op_is_signed(input div_op_t op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic op_is_rem(input div_op_t op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/ex_div_seq_if.sv
// Handshake and operand/result bundle between the EX stage and the divide sequencer.
interface ex_div_seq_if #(
    parameter int XLEN = 32
);
    logic            Start;
    logic [1:0]      Div_op;
    logic [XLEN-1:0] Op_a;
    logic [XLEN-1:0] Op_b;
    logic            Flush;
    logic            Stall;
    logic            Busy;
    logic            Done;
    logic [XLEN-1:0] Result;

    modport master (
        output Start, Div_op, Op_a, Op_b, Flush,
        input  Stall, Busy, Done, Result
    );

    modport slave (
        input  Start, Div_op, Op_a, Op_b, Flush,
        output Stall, Busy, Done, Result
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the remainder,
// then subtract the divisor and record a quotient bit when it fits.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] dvd,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] dvd_next
);

    logic            carry_s;
    logic [XLEN-1:0] shifted_s;

    // The bit shifted out of rem is kept as a carry so divisors >= 2^(XLEN-1) still compare correctly.
    always_comb begin
        carry_s   = rem[XLEN-1];
        shifted_s = {rem[XLEN-2:0], dvd[XLEN-1]};
        if (carry_s || (shifted_s >= divisor)) begin
            rem_next = shifted_s - divisor;
            dvd_next = {dvd[XLEN-2:0], 1'b1};
        end else begin
            rem_next = shifted_s;
            dvd_next = {dvd[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_div_seq.sv
// RV32M DIV/DIVU/REM/REMU sequencer: captures operands from EX, iterates a
// 32-step restoring division while stalling the pipe, then pulses Done with Result.
module ex_div_seq
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic         Clk,
    input logic         Reset,
    ex_div_seq_if.slave bus
);

    localparam int             CW   = $clog2(XLEN);
    localparam logic [CW-1:0]  LAST = CW'(XLEN - 1);

    div_state_t      state_r, state_nxt_s;
    div_op_t         op_r, op_s;
    logic [CW-1:0]   cnt_r;
    logic [XLEN-1:0] rem_r, dvd_r, dsr_r;
    logic            neg_q_r, neg_r_r;
    logic            busy_r, done_r;
    logic [XLEN-1:0] result_r;

    logic            capture_s, step_s, finish_s;
    logic            a_neg_s, b_neg_s, div0_s, ovf_s, special_s;
    logic [XLEN-1:0] abs_a_s, abs_b_s, special_res_s, final_s;
    logic [XLEN-1:0] rem_next_s, dvd_next_s;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + XLEN'(1)) : v;
    endfunction

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_r),
        .dvd      (dvd_r),
        .divisor  (dsr_r),
        .rem_next (rem_next_s),
        .dvd_next (dvd_next_s)
    );

    // Operand decode at capture: magnitudes, signs and the two RISC-V special cases.
    always_comb begin
        op_s      = div_op_t'(bus.Div_op);
        a_neg_s   = op_is_signed(op_s) & bus.Op_a[XLEN-1];
        b_neg_s   = op_is_signed(op_s) & bus.Op_b[XLEN-1];
        abs_a_s   = cond_neg(bus.Op_a, a_neg_s);
        abs_b_s   = cond_neg(bus.Op_b, b_neg_s);
        div0_s    = (bus.Op_b == '0);
        ovf_s     = op_is_signed(op_s) && (bus.Op_a == DIV_OVF_QUOT) && (bus.Op_b == DIV_QUOT_BY_ZERO);
        special_s = div0_s | ovf_s;
        if (div0_s) begin
            special_res_s = op_is_rem(op_s) ? bus.Op_a : DIV_QUOT_BY_ZERO;
        end else if (op_is_rem(op_s)) begin
            special_res_s = '0;
        end else begin
            special_res_s = DIV_OVF_QUOT;
        end
    end

    // Final result selection with sign correction, taken from the last step's outputs.
    always_comb begin
        if (op_is_rem(op_r)) begin
            final_s = cond_neg(rem_next_s, neg_r_r);
        end else begin
            final_s = cond_neg(dvd_next_s, neg_q_r);
        end
    end

    // Next-state logic; Flush overrides everything and Start is only sampled in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        step_s      = 1'b0;
        finish_s    = 1'b0;
        if (bus.Flush) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.Start) begin
                        capture_s   = 1'b1;
                        state_nxt_s = special_s ? DONE : RUN;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                RUN: begin
                    step_s = 1'b1;
                    if (cnt_r == LAST) begin
                        finish_s    = 1'b1;
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                DONE:    state_nxt_s = IDLE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath: operand capture, iteration registers, counter and registered status outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            op_r     <= DIV;
            cnt_r    <= '0;
            rem_r    <= '0;
            dvd_r    <= '0;
            dsr_r    <= '0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= '0;
        end else begin
            busy_r <= (state_nxt_s == RUN);
            done_r <= (state_nxt_s == DONE);
            if (capture_s) begin
                op_r    <= op_s;
                neg_q_r <= a_neg_s ^ b_neg_s;
                neg_r_r <= a_neg_s;
                dvd_r   <= abs_a_s;
                dsr_r   <= abs_b_s;
                rem_r   <= '0;
                cnt_r   <= '0;
                if (special_s) begin
                    result_r <= special_res_s;
                end else begin
                    result_r <= result_r;
                end
            end else if (step_s) begin
                rem_r <= rem_next_s;
                dvd_r <= dvd_next_s;
                cnt_r <= cnt_r + CW'(1);
                if (finish_s) begin
                    result_r <= final_s;
                end else begin
                    result_r <= result_r;
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign bus.Stall  = bus.Start & ~done_r;
    assign bus.Busy   = busy_r;
    assign bus.Done   = done_r;
    assign bus.Result = result_r;

endmodule

// File: tb/tb_ex_div_seq.sv
// Scoreboard bench for ex_div_seq: directed RV32M cases, flush/reset scenarios and
// random operands against an arithmetic reference model.
module tb_ex_div_seq;
    import ex_pkg::*;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] last_res = 32'h0;

    typedef struct {
        string       nm;
        logic [31:0] res;
        int          lat;
        int          issue;
    } exp_t;
    exp_t exp_q[$];

    ex_div_seq_if #(.XLEN(32)) bus();
    ex_div_seq #(.XLEN(32)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // RISC-V M-extension semantics expressed with plain arithmetic.
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, sq, sr;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
        if (!op[0]) begin
            sq = sa / sb;
            sr = sa % sb;
            return op[1] ? sr : sq;
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    // Issue one op (called just after a posedge), hold Start until Done, then drop Start after the Done edge.
    task automatic do_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        exp_t e;
        int   stalls;
        bit   seen;
        e.nm    = nm;
        e.res   = exp;
        e.lat   = is_special(op, a, b) ? 1 : 33;
        e.issue = cyc;
        exp_q.push_back(e);
        bus.Div_op = op;
        bus.Op_a   = a;
        bus.Op_b   = b;
        bus.Start  = 1'b1;
        stalls = 0;
        seen   = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge Clk);
            if (bus.Done) begin
                seen = 1'b1;
                chk({nm, "_stall_in_done"}, {31'd0, bus.Stall}, 32'd0);
            end else begin
                if (bus.Stall) stalls++;
                if (i == 1) begin
                    bus.Op_a   = ~a;
                    bus.Op_b   = $urandom;
                    bus.Div_op = ~op;
                end
            end
        end
        if (!seen) begin
            chk({nm, "_timeout"}, 32'd0, 32'd1);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
            chk({nm, "_stall_cycles"}, stalls, e.lat);
        end
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        last_res  = exp;
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        exp_t e;
        if (!Reset && bus.Done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: Result=%h with nothing outstanding (cycle %0d)", bus.Result, cyc);
            end else begin
                e = exp_q.pop_front();
                chk({e.nm, "_result"}, bus.Result, e.res);
                chk({e.nm, "_latency"}, cyc - e.issue, e.lat);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        int          sel;
        bus.Start  = 1'b0;
        bus.Flush  = 1'b0;
        bus.Div_op = 2'b00;
        bus.Op_a   = 32'd0;
        bus.Op_b   = 32'd0;
        repeat (2) @(negedge Clk);
        chk("reset_busy",   {31'd0, bus.Busy},  32'd0);
        chk("reset_done",   {31'd0, bus.Done},  32'd0);
        chk("reset_result", bus.Result,         32'd0);
        chk("reset_stall",  {31'd0, bus.Stall}, 32'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(posedge Clk);
        #1;

        do_op("div_100_7",   DIV,  32'd100,       32'd7,         32'd14);
        do_op("rem_100_7",   REM,  32'd100,       32'd7,         32'd2);
        do_op("div_m7_2",    DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        do_op("rem_m7_2",    REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
        do_op("remu_7_big",  REMU, 32'd7,         32'hFFFF_FFFE, 32'd7);
        do_op("divu_5_0",    DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF);
        do_op("remu_5_0",    REMU, 32'd5,         32'd0,         32'd5);
        do_op("div_ovf",     DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        do_op("rem_ovf",     REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        do_op("divu_big",    DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1);
        do_op("div_100_7b",  DIV,  32'd100,       32'd7,         32'd14);

        // Flush in cycle 10 of RUN: block must drop back to IDLE silently.
        bus.Div_op = DIVU;
        bus.Op_a   = 32'd1000;
        bus.Op_b   = 32'd3;
        bus.Start  = 1'b1;
        repeat (10) @(posedge Clk);
        #1;
        bus.Flush = 1'b1;
        bus.Start = 1'b0;
        @(posedge Clk);
        #1;
        bus.Flush = 1'b0;
        @(negedge Clk);
        chk("flush_busy",   {31'd0, bus.Busy}, 32'd0);
        chk("flush_done",   {31'd0, bus.Done}, 32'd0);
        chk("flush_result", bus.Result,        last_res);
        @(posedge Clk);
        #1;
        do_op("after_flush", DIV, 32'd200, 32'hFFFF_FFF6, 32'hFFFF_FFEC);

        // Flush coinciding with Start: Stall follows Start, but nothing is captured.
        bus.Div_op = DIV;
        bus.Op_a   = 32'd50;
        bus.Op_b   = 32'd5;
        bus.Start  = 1'b1;
        bus.Flush  = 1'b1;
        @(negedge Clk);
        chk("flush_start_stall", {31'd0, bus.Stall}, 32'd1);
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        bus.Flush = 1'b0;
        @(negedge Clk);
        chk("flush_start_busy", {31'd0, bus.Busy}, 32'd0);
        @(posedge Clk);
        #1;

        // Asynchronous reset in the middle of RUN, with Start held through it.
        bus.Div_op = DIV;
        bus.Op_a   = 32'd100;
        bus.Op_b   = 32'd7;
        bus.Start  = 1'b1;
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        chk("pre_reset_busy", {31'd0, bus.Busy}, 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_reset_busy",   {31'd0, bus.Busy}, 32'd0);
        chk("async_reset_done",   {31'd0, bus.Done}, 32'd0);
        chk("async_reset_result", bus.Result,        32'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        do_op("held_start", DIV,  32'd100, 32'd7, 32'd14);
        do_op("b2b_second", REMU, 32'd1001, 32'd10, 32'd1);

        for (int n = 0; n < 24; n++) begin
            op  = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 7);
            a   = $urandom;
            b   = $urandom;
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) b = 32'($urandom_range(1, 15));
            else if (sel == 3) b = -32'($urandom_range(1, 15));
            do_op($sformatf("rand%0d", n), op, a, b, ref_div(op, a, b));
        end

        repeat (5) @(posedge Clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
